// File: rtl/width_pkg.sv
`default_nettype none
// ============================================================================
// Module  : width_pkg
// Brief   : Shared states, mode codes and the narrow->wide zero-extend helper
//           for the width_gearbox stream converter.
// Revision: 1.0
// ============================================================================
package width_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } gb_state_e;

    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

    // Widest narrow lane the helper can carry; callers cast down to their width.
    localparam int GB_MAX_W = 64;

    function automatic logic [2*GB_MAX_W-1:0] zext_narrow(
        input logic [GB_MAX_W-1:0] narrow,
        input int                  width
    );
        logic [GB_MAX_W-1:0] mask;
        mask = (GB_MAX_W'(1) << width) - GB_MAX_W'(1);
        return {{GB_MAX_W{1'b0}}, narrow & mask};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gb_lane_sel.sv
`default_nettype none
// ============================================================================
// Module  : gb_lane_sel
// Brief   : Picks first/second narrow half of a wide word (zero-extended) and
//           places an incoming narrow beat into the first/second half.
// Revision: 1.0
// ============================================================================
module gb_lane_sel
    import width_pkg::*;
#(
    parameter int NARROW_W  = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [2*NARROW_W-1:0] i_word,
    input  logic [NARROW_W-1:0]   i_beat,
    output logic [2*NARROW_W-1:0] o_first,
    output logic [2*NARROW_W-1:0] o_second,
    output logic [2*NARROW_W-1:0] o_beat_first,
    output logic [2*NARROW_W-1:0] o_beat_second
);
    localparam int WIDE_W = 2 * NARROW_W;

    function automatic logic [WIDE_W-1:0] zx(input logic [NARROW_W-1:0] v);
        return WIDE_W'(zext_narrow(GB_MAX_W'(v), NARROW_W));
    endfunction

    logic [NARROW_W-1:0] w_lo;
    logic [NARROW_W-1:0] w_hi;
    logic [WIDE_W-1:0]   w_beat_lo;
    logic [WIDE_W-1:0]   w_beat_hi;

    assign w_lo      = i_word[NARROW_W-1:0];
    assign w_hi      = i_word[WIDE_W-1:NARROW_W];
    assign w_beat_lo = zx(i_beat);
    assign w_beat_hi = {i_beat, {NARROW_W{1'b0}}};

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign o_first       = zx(w_lo);
            assign o_second      = zx(w_hi);
            assign o_beat_first  = w_beat_lo;
            assign o_beat_second = w_beat_hi;
        end else begin : g_msb_first
            assign o_first       = zx(w_hi);
            assign o_second      = zx(w_lo);
            assign o_beat_first  = w_beat_hi;
            assign o_beat_second = w_beat_lo;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/width_gearbox.sv
`default_nettype none
// ============================================================================
// Module  : width_gearbox
// Brief   : Narrow <-> 2x-wide stream width converter with valid/ready on both
//           sides. Define WIDTH_GEARBOX_CNT_EN to add the xfer_cnt port.
// Revision: 1.0
// ============================================================================
module width_gearbox
    import width_pkg::*;
#(
    parameter int NARROW_W  = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  flush,
    output logic                  busy,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [2*NARROW_W-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*NARROW_W-1:0] m_data
`ifdef WIDTH_GEARBOX_CNT_EN
    ,
    output logic [15:0]           xfer_cnt
`endif
);
    localparam int WIDE_W = 2 * NARROW_W;

    gb_state_e         state_q, state_d;
    logic              mode_q, mode_d;
    logic [WIDE_W-1:0] buf_q, buf_d;

    logic [WIDE_W-1:0] w_first;
    logic [WIDE_W-1:0] w_second;
    logic [WIDE_W-1:0] w_beat_first;
    logic [WIDE_W-1:0] w_beat_second;

    gb_lane_sel #(
        .NARROW_W  (NARROW_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_lane_sel (
        .i_word        (buf_q),
        .i_beat        (s_data[NARROW_W-1:0]),
        .o_first       (w_first),
        .o_second      (w_second),
        .o_beat_first  (w_beat_first),
        .o_beat_second (w_beat_second)
    );

    assign busy = (state_q != S_EMPTY);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        buf_d   = buf_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        case (state_q)
            S_EMPTY: begin
                // Outside S_EMPTY the captured mode governs; here the live pin does.
                mode_d  = mode;
                s_ready = 1'b1;
                if (s_valid) begin
                    if (mode == MODE_DOWN) begin
                        buf_d   = s_data;
                        state_d = S_TWO;
                    end else begin
                        buf_d   = w_beat_first;
                        state_d = S_ONE;
                    end
                end
            end
            S_ONE: begin
                if (mode_q == MODE_DOWN) begin
                    m_valid = 1'b1;
                    m_data  = w_second;
                    s_ready = m_ready;
                    if (m_ready) begin
                        if (s_valid) begin
                            buf_d   = s_data;
                            state_d = S_TWO;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end
                end else begin
                    s_ready = 1'b1;
                    // The second half is already zero, so a flush just closes the word.
                    if (s_valid) begin
                        buf_d   = buf_q | w_beat_second;
                        state_d = S_TWO;
                    end else if (flush) begin
                        state_d = S_TWO;
                    end
                end
            end
            S_TWO: begin
                m_valid = 1'b1;
                if (mode_q == MODE_DOWN) begin
                    m_data = w_first;
                    if (m_ready) begin
                        state_d = S_ONE;
                    end
                end else begin
                    m_data  = buf_q;
                    s_ready = m_ready;
                    if (m_ready) begin
                        if (s_valid) begin
                            buf_d   = w_beat_first;
                            state_d = S_ONE;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            mode_q  <= MODE_DOWN;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            buf_q   <= buf_d;
        end
    end

`ifdef WIDTH_GEARBOX_CNT_EN
    logic        w_eff_mode;
    logic        w_word_xfer;
    logic [15:0] cnt_q, cnt_d;

    // Wide side is the source in down mode and the sink in up mode.
    assign w_eff_mode  = (state_q == S_EMPTY) ? mode : mode_q;
    assign w_word_xfer = (w_eff_mode == MODE_DOWN) ? (s_valid && s_ready)
                                                   : (m_valid && m_ready);

    always_comb begin
        cnt_d = cnt_q + 16'(w_word_xfer);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_width_gearbox.sv
`default_nettype none
// ============================================================================
// Module  : tb_width_gearbox
// Brief   : Two gearboxes (LSB-first and MSB-first) driven in lockstep and
//           compared every cycle against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_width_gearbox;
    import width_pkg::*;

    localparam int NW = 4;
    localparam int WW = 2 * NW;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          mode    = 1'b0;
    logic          flush   = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [WW-1:0] s_data  = '0;

    logic          busy_l, s_ready_l, m_valid_l;
    logic          busy_h, s_ready_h, m_valid_h;
    logic [WW-1:0] m_data_l, m_data_h;
`ifdef WIDTH_GEARBOX_CNT_EN
    logic [15:0]   cnt_l, cnt_h;
`endif

    always #5 clk = ~clk;

    width_gearbox #(.NARROW_W(NW), .LSB_FIRST(1'b1)) u_dut_lsb (
        .clk(clk), .rst(rst), .mode(mode), .flush(flush), .busy(busy_l),
        .s_valid(s_valid), .s_ready(s_ready_l), .s_data(s_data),
        .m_valid(m_valid_l), .m_ready(m_ready), .m_data(m_data_l)
`ifdef WIDTH_GEARBOX_CNT_EN
        , .xfer_cnt(cnt_l)
`endif
    );

    width_gearbox #(.NARROW_W(NW), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk(clk), .rst(rst), .mode(mode), .flush(flush), .busy(busy_h),
        .s_valid(s_valid), .s_ready(s_ready_h), .s_data(s_data),
        .m_valid(m_valid_h), .m_ready(m_ready), .m_data(m_data_h)
`ifdef WIDTH_GEARBOX_CNT_EN
        , .xfer_cnt(cnt_h)
`endif
    );

    // Model: held narrow units in output order (down) or arrival order (up).
    logic [NW-1:0] qa[$];
    logic [NW-1:0] qb[$];
    logic          mmode = MODE_DOWN;
    logic [15:0]   cnt_m = '0;

    int checks   = 0;
    int failures = 0;

    function automatic logic md_cur();
        return (qa.size() == 0) ? mode : mmode;
    endfunction

    function automatic logic exp_mvalid();
        if (md_cur() == MODE_DOWN) return qa.size() > 0;
        return qa.size() == 2;
    endfunction

    function automatic logic exp_sready();
        if (md_cur() == MODE_DOWN) return (qa.size() == 0) || (qa.size() == 1 && m_ready);
        return (qa.size() < 2) || m_ready;
    endfunction

    function automatic logic [WW-1:0] exp_data(input bit lsb);
        logic [NW-1:0] b0, b1;
        if (!exp_mvalid()) return '0;
        b0 = lsb ? qa[0] : qb[0];
        if (md_cur() == MODE_DOWN) return {{NW{1'b0}}, b0};
        b1 = lsb ? qa[1] : qb[1];
        return lsb ? {b1, b0} : {b0, b1};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        mmode = MODE_DOWN;
        cnt_m = '0;
    endtask

    task automatic model_step();
        int   sz;
        logic md;
        bit   xs, xm;
        sz = qa.size();
        md = md_cur();
        xs = s_valid && exp_sready();
        xm = exp_mvalid() && m_ready;
        if (md == MODE_DOWN) begin
            if (xm) begin
                qa.delete(0);
                qb.delete(0);
            end
            if (xs) begin
                qa.push_back(s_data[NW-1:0]);
                qa.push_back(s_data[WW-1:NW]);
                qb.push_back(s_data[WW-1:NW]);
                qb.push_back(s_data[NW-1:0]);
                cnt_m++;
            end
        end else begin
            if (xm) begin
                qa.delete();
                qb.delete();
                cnt_m++;
            end
            if (xs) begin
                qa.push_back(s_data[NW-1:0]);
                qb.push_back(s_data[NW-1:0]);
            end else if (sz == 1 && flush) begin
                qa.push_back('0);
                qb.push_back('0);
            end
        end
        mmode = md;
    endtask

    task automatic compare();
        chk("m_valid_l", 16'(m_valid_l), 16'(exp_mvalid()));
        chk("m_valid_h", 16'(m_valid_h), 16'(exp_mvalid()));
        chk("s_ready_l", 16'(s_ready_l), 16'(exp_sready()));
        chk("s_ready_h", 16'(s_ready_h), 16'(exp_sready()));
        chk("busy_l", 16'(busy_l), 16'(qa.size() != 0));
        chk("busy_h", 16'(busy_h), 16'(qa.size() != 0));
        chk("m_data_l", 16'(m_data_l), 16'(exp_data(1'b1)));
        chk("m_data_h", 16'(m_data_h), 16'(exp_data(1'b0)));
`ifdef WIDTH_GEARBOX_CNT_EN
        chk("xfer_cnt_l", cnt_l, cnt_m);
        chk("xfer_cnt_h", cnt_h, cnt_m);
`endif
    endtask

    // Called just after a negedge once inputs are set.
    task automatic cyc();
        #1;
        compare();
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_m_valid", 16'(m_valid_l), 16'h0);
        chk("rst_m_data", 16'(m_data_h), 16'h0);
        chk("rst_busy", 16'(busy_l), 16'h0);
        chk("rst_s_ready", 16'(s_ready_h), 16'h1);
        compare();
        rst = 1'b0;
        adv();

        // Down split of A5
        mode = MODE_DOWN; m_ready = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
        cyc(); adv();
        s_valid = 1'b0;
        cyc();
        chk("dn_a5_b0_l", 16'(m_data_l), 16'h05);
        chk("dn_a5_b0_h", 16'(m_data_h), 16'h0A);
        chk("dn_a5_busy", 16'(busy_l), 16'h1);
        adv();
        cyc();
        chk("dn_a5_b1_l", 16'(m_data_l), 16'h0A);
        chk("dn_a5_b1_h", 16'(m_data_h), 16'h05);
        adv();
        cyc();
        chk("dn_a5_idle", 16'(busy_l), 16'h0);

        // Down back-to-back 3C, F1
        s_valid = 1'b1; s_data = 8'h3C;
        cyc(); adv();
        s_data = 8'hF1;
        cyc();
        chk("b2b_0", 16'(m_data_l), 16'h0C);
        chk("b2b_rdy0", 16'(s_ready_l), 16'h0);
        adv();
        cyc();
        chk("b2b_1", 16'(m_data_l), 16'h03);
        chk("b2b_rdy1", 16'(s_ready_l), 16'h1);
        adv();
        s_valid = 1'b0;
        cyc();
        chk("b2b_2", 16'(m_data_l), 16'h01);
        adv();
        cyc();
        chk("b2b_3", 16'(m_data_l), 16'h0F);
        adv();

        // Up pack 7,2
        mode = MODE_UP; s_valid = 1'b1; s_data = 8'h07;
        cyc(); adv();
        s_data = 8'h02;
        cyc(); adv();
        s_valid = 1'b0;
        cyc();
        chk("up_72_l", 16'(m_data_l), 16'h27);
        chk("up_72_h", 16'(m_data_h), 16'h72);
        adv();

        // Odd beat then flush
        s_valid = 1'b1; s_data = 8'h09;
        cyc(); adv();
        s_valid = 1'b0; flush = 1'b1;
        cyc(); adv();
        flush = 1'b0;
        cyc();
        chk("flush_l", 16'(m_data_l), 16'h09);
        chk("flush_h", 16'(m_data_h), 16'h90);
        adv();

        // Flush together with a beat: beat wins, upper input bits ignored
        s_valid = 1'b1; s_data = 8'hF9;
        cyc(); adv();
        s_data = 8'h34; flush = 1'b1;
        cyc(); adv();
        s_valid = 1'b0; flush = 1'b0;
        cyc();
        chk("flush_beat_l", 16'(m_data_l), 16'h49);
        chk("flush_beat_h", 16'(m_data_h), 16'h94);
        adv();

        // Backpressure with mode toggling while stalled in S_TWO
        mode = MODE_DOWN; m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h5A;
        cyc(); adv();
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mode = ~mode;
            cyc();
            chk("stall_data", 16'(m_data_l), 16'h0A);
            chk("stall_rdy", 16'(s_ready_l), 16'h0);
            adv();
        end
        mode = MODE_UP; m_ready = 1'b1;
        cyc();
        chk("stall_rel0", 16'(m_data_l), 16'h0A);
        adv();
        cyc();
        chk("stall_rel1", 16'(m_data_l), 16'h05);
        adv();
        mode = MODE_DOWN;
        cyc(); adv();

        // Reset while in S_ONE of down mode
        s_valid = 1'b1; s_data = 8'hC3;
        cyc(); adv();
        s_valid = 1'b0;
        cyc(); adv();
        cyc();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_valid", 16'(m_valid_l), 16'h0);
        chk("rst_mid_busy", 16'(busy_l), 16'h0);
        chk("rst_mid_data", 16'(m_data_l), 16'h0);
`ifdef WIDTH_GEARBOX_CNT_EN
        chk("rst_mid_cnt", cnt_l, 16'h0);
`endif
        compare();
        adv();
        rst = 1'b0;
        cyc(); adv();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            s_valid = ($urandom_range(0, 9) < 7);
            m_ready = ($urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 3) == 0);
            s_data  = WW'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            cyc();
            adv();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
